adbg_axi_mem_slave: RTL and testbench

ADBG_AXI_MEM_SLAVE -- requirements
Module: adbg_axi_mem_slave

---
 rtl/adbg_axi_mem_slave.sv | 261 ++++++++++++++++++++++++++
 tb/tb_adbg_axi_mem_slave.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adbg_axi_mem_slave.sv
// Single-outstanding AXI4 responder backed by a MEM_DEPTH x AXI_DATA_WIDTH word array.
// Define ADBG_AXI_MEM_SLAVE_RANGE_CHECK_EN to answer DECERR for addresses beyond the array.
module adbg_axi_mem_slave #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 3,
   parameter int AXI_USER_WIDTH = 6,
   parameter int MEM_DEPTH      = 256
) (
   input  logic                        axi_aclk,
   input  logic                        axi_aresetn,

   input  logic                        axi_slave_aw_valid,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr,
   input  logic [7:0]                  axi_slave_aw_len,
   input  logic [2:0]                  axi_slave_aw_size,
   input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id,
   input  logic [2:0]                  axi_slave_aw_prot,
   input  logic [3:0]                  axi_slave_aw_region,
   input  logic [1:0]                  axi_slave_aw_burst,
   input  logic                        axi_slave_aw_lock,
   input  logic [3:0]                  axi_slave_aw_cache,
   input  logic [3:0]                  axi_slave_aw_qos,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_aw_user,
   output logic                        axi_slave_aw_ready,

   input  logic                        axi_slave_w_valid,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb,
   input  logic                        axi_slave_w_last,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_w_user,
   output logic                        axi_slave_w_ready,

   output logic                        axi_slave_b_valid,
   output logic [1:0]                  axi_slave_b_resp,
   output logic [AXI_ID_WIDTH-1:0]     axi_slave_b_id,
   output logic [AXI_USER_WIDTH-1:0]   axi_slave_b_user,
   input  logic                        axi_slave_b_ready,

   input  logic                        axi_slave_ar_valid,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr,
   input  logic [7:0]                  axi_slave_ar_len,
   input  logic [2:0]                  axi_slave_ar_size,
   input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id,
   input  logic [2:0]                  axi_slave_ar_prot,
   input  logic [3:0]                  axi_slave_ar_region,
   input  logic [1:0]                  axi_slave_ar_burst,
   input  logic                        axi_slave_ar_lock,
   input  logic [3:0]                  axi_slave_ar_cache,
   input  logic [3:0]                  axi_slave_ar_qos,
   input  logic [AXI_USER_WIDTH-1:0]   axi_slave_ar_user,
   output logic                        axi_slave_ar_ready,

   output logic                        axi_slave_r_valid,
   output logic [AXI_DATA_WIDTH-1:0]   axi_slave_r_data,
   output logic [1:0]                  axi_slave_r_resp,
   output logic                        axi_slave_r_last,
   output logic [AXI_ID_WIDTH-1:0]     axi_slave_r_id,
   output logic [AXI_USER_WIDTH-1:0]   axi_slave_r_user,
   input  logic                        axi_slave_r_ready
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_DEPTH);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_W  = 3'd1,
      WAIT_AW = 3'd2,
      WR_RESP = 3'd3,
      RD_RESP = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                      ready_en_q;
   logic [IDX_W-1:0]          aw_idx_q;
   logic                      aw_oor_q;
   logic [7:0]                aw_len_q;
   logic [AXI_ID_WIDTH-1:0]   aw_id_q;
   logic [AXI_DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]         w_strb_q;
   logic [AXI_ID_WIDTH-1:0]   ar_id_q;
   logic [AXI_DATA_WIDTH-1:0] r_data_q;
   logic [1:0]                b_resp_q;
   logic [1:0]                r_resp_q;

   logic [IDX_W-1:0]          aw_idx, ar_idx, wr_idx;
   logic                      aw_oor, ar_oor, wr_oor;
   logic [7:0]                wr_len;
   logic [AXI_DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]         wr_strb;
   logic                      wr_fire;
   logic [1:0]                wr_resp, rd_resp;
   logic                      aw_hs, w_hs, ar_hs;
   logic                      unused_inputs;
   logic                      unused_addr;

   function automatic logic [1:0] resp_of(input logic oor, input logic [7:0] len);
      logic [1:0] resp;
      resp = (len != 8'd0) ? RESP_SLVERR : RESP_OKAY;
      if (oor) resp = RESP_DECERR;
      return resp;
   endfunction

   assign aw_idx = axi_slave_aw_addr[IDX_W+OFF_W-1:OFF_W];
   assign ar_idx = axi_slave_ar_addr[IDX_W+OFF_W-1:OFF_W];

`ifdef ADBG_AXI_MEM_SLAVE_RANGE_CHECK_EN
   assign aw_oor      = |axi_slave_aw_addr[AXI_ADDR_WIDTH-1:IDX_W+OFF_W];
   assign ar_oor      = |axi_slave_ar_addr[AXI_ADDR_WIDTH-1:IDX_W+OFF_W];
   assign unused_addr = ^{axi_slave_aw_addr[OFF_W-1:0], axi_slave_ar_addr[OFF_W-1:0]};
`else
   // Upper address bits are dropped so the word index wraps modulo MEM_DEPTH.
   assign aw_oor      = 1'b0;
   assign ar_oor      = 1'b0;
   assign unused_addr = ^{axi_slave_aw_addr[OFF_W-1:0], axi_slave_ar_addr[OFF_W-1:0],
                          axi_slave_aw_addr[AXI_ADDR_WIDTH-1:IDX_W+OFF_W],
                          axi_slave_ar_addr[AXI_ADDR_WIDTH-1:IDX_W+OFF_W]};
`endif

   assign unused_inputs = ^{axi_slave_aw_size, axi_slave_aw_prot, axi_slave_aw_region,
                            axi_slave_aw_burst, axi_slave_aw_lock, axi_slave_aw_cache,
                            axi_slave_aw_qos, axi_slave_aw_user, axi_slave_w_last,
                            axi_slave_w_user, axi_slave_ar_size, axi_slave_ar_prot,
                            axi_slave_ar_region, axi_slave_ar_burst, axi_slave_ar_lock,
                            axi_slave_ar_cache, axi_slave_ar_qos, axi_slave_ar_user};

   // Write fields come from the live channel when its handshake completes the write,
   // otherwise from what was latched while waiting for the other channel.
   always_comb begin
      state_d            = state_q;
      axi_slave_aw_ready = 1'b0;
      axi_slave_w_ready  = 1'b0;
      axi_slave_ar_ready = 1'b0;
      wr_fire            = 1'b0;
      wr_idx             = aw_idx_q;
      wr_oor             = aw_oor_q;
      wr_len             = aw_len_q;
      wr_data            = w_data_q;
      wr_strb            = w_strb_q;
      case (state_q)
         IDLE: begin
            axi_slave_aw_ready = ready_en_q;
            axi_slave_w_ready  = ready_en_q;
            axi_slave_ar_ready = ready_en_q & ~axi_slave_aw_valid & ~axi_slave_w_valid;
            if (ready_en_q) begin
               if (axi_slave_aw_valid && axi_slave_w_valid) begin
                  wr_fire = 1'b1;
                  wr_idx  = aw_idx;
                  wr_oor  = aw_oor;
                  wr_len  = axi_slave_aw_len;
                  wr_data = axi_slave_w_data;
                  wr_strb = axi_slave_w_strb;
                  state_d = WR_RESP;
               end else if (axi_slave_aw_valid) begin
                  state_d = WAIT_W;
               end else if (axi_slave_w_valid) begin
                  state_d = WAIT_AW;
               end else if (axi_slave_ar_valid) begin
                  state_d = RD_RESP;
               end
            end
         end
         WAIT_W: begin
            axi_slave_w_ready = 1'b1;
            if (axi_slave_w_valid) begin
               wr_fire = 1'b1;
               wr_data = axi_slave_w_data;
               wr_strb = axi_slave_w_strb;
               state_d = WR_RESP;
            end
         end
         WAIT_AW: begin
            axi_slave_aw_ready = 1'b1;
            if (axi_slave_aw_valid) begin
               wr_fire = 1'b1;
               wr_idx  = aw_idx;
               wr_oor  = aw_oor;
               wr_len  = axi_slave_aw_len;
               state_d = WR_RESP;
            end
         end
         WR_RESP: if (axi_slave_b_ready) state_d = IDLE;
         RD_RESP: if (axi_slave_r_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign aw_hs   = axi_slave_aw_valid & axi_slave_aw_ready;
   assign w_hs    = axi_slave_w_valid & axi_slave_w_ready;
   assign ar_hs   = axi_slave_ar_valid & axi_slave_ar_ready;
   assign wr_resp = resp_of(wr_oor, wr_len);
   assign rd_resp = resp_of(ar_oor, axi_slave_ar_len);

   // ready_en_q keeps every ready low until the first clock after reset release.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q    <= IDLE;
         ready_en_q <= 1'b0;
         aw_idx_q   <= '0;
         aw_oor_q   <= 1'b0;
         aw_len_q   <= '0;
         aw_id_q    <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         ar_id_q    <= '0;
         r_data_q   <= '0;
         b_resp_q   <= '0;
         r_resp_q   <= '0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
         if (aw_hs) begin
            aw_idx_q <= aw_idx;
            aw_oor_q <= aw_oor;
            aw_len_q <= axi_slave_aw_len;
            aw_id_q  <= axi_slave_aw_id;
         end
         if (w_hs) begin
            w_data_q <= axi_slave_w_data;
            w_strb_q <= axi_slave_w_strb;
         end
         if (wr_fire) b_resp_q <= wr_resp;
         if (ar_hs) begin
            ar_id_q  <= axi_slave_ar_id;
            r_resp_q <= rd_resp;
            r_data_q <= (rd_resp == RESP_OKAY) ? mem[ar_idx] : '0;
         end
      end
   end

   // Storage is deliberately outside the reset domain so contents survive a reset.
   always_ff @(posedge axi_aclk) begin
      if (wr_fire && (wr_resp == RESP_OKAY)) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   assign axi_slave_b_valid = (state_q == WR_RESP);
   assign axi_slave_b_resp  = b_resp_q;
   assign axi_slave_b_id    = aw_id_q;
   assign axi_slave_b_user  = '0;

   assign axi_slave_r_valid = (state_q == RD_RESP);
   assign axi_slave_r_last  = (state_q == RD_RESP);
   assign axi_slave_r_data  = r_data_q;
   assign axi_slave_r_resp  = r_resp_q;
   assign axi_slave_r_id    = ar_id_q;
   assign axi_slave_r_user  = '0;

endmodule

// File: tb/tb_adbg_axi_mem_slave.sv
// Scoreboard bench for adbg_axi_mem_slave: byte-array reference model, queued expectations,
// independent b/r monitor. Honours ADBG_AXI_MEM_SLAVE_RANGE_CHECK_EN when computing expectations.
module tb_adbg_axi_mem_slave;

   logic        clk = 1'b0;
   logic        axi_aresetn;
   logic        aw_valid, aw_ready, aw_lock, w_valid, w_ready, w_last;
   logic [31:0] aw_addr, ar_addr;
   logic [7:0]  aw_len, ar_len, w_strb;
   logic [2:0]  aw_size, aw_id, aw_prot, ar_size, ar_id, ar_prot, b_id, r_id;
   logic [3:0]  aw_region, aw_cache, aw_qos, ar_region, ar_cache, ar_qos;
   logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
   logic [5:0]  aw_user, w_user, ar_user, b_user, r_user;
   logic [63:0] w_data, r_data;
   logic        b_valid, b_ready, ar_valid, ar_ready, ar_lock, r_valid, r_last, r_ready;

   int checks = 0;
   int errors = 0;
   int bp_mode = 2;   // 0: random ready, 1: ready low, 2: ready high

   typedef struct {
      logic [1:0]  resp;
      logic [2:0]  id;
      logic [63:0] data;
   } exp_t;

   exp_t exp_b[$];
   exp_t exp_r[$];
   byte unsigned ref_mem [2048];

   always #5 clk = ~clk;

   adbg_axi_mem_slave #(
      .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(3),
      .AXI_USER_WIDTH(6), .MEM_DEPTH(256)
   ) dut (
      .axi_aclk(clk), .axi_aresetn(axi_aresetn),
      .axi_slave_aw_valid(aw_valid), .axi_slave_aw_addr(aw_addr), .axi_slave_aw_len(aw_len),
      .axi_slave_aw_size(aw_size), .axi_slave_aw_id(aw_id), .axi_slave_aw_prot(aw_prot),
      .axi_slave_aw_region(aw_region), .axi_slave_aw_burst(aw_burst), .axi_slave_aw_lock(aw_lock),
      .axi_slave_aw_cache(aw_cache), .axi_slave_aw_qos(aw_qos), .axi_slave_aw_user(aw_user),
      .axi_slave_aw_ready(aw_ready),
      .axi_slave_w_valid(w_valid), .axi_slave_w_data(w_data), .axi_slave_w_strb(w_strb),
      .axi_slave_w_last(w_last), .axi_slave_w_user(w_user), .axi_slave_w_ready(w_ready),
      .axi_slave_b_valid(b_valid), .axi_slave_b_resp(b_resp), .axi_slave_b_id(b_id),
      .axi_slave_b_user(b_user), .axi_slave_b_ready(b_ready),
      .axi_slave_ar_valid(ar_valid), .axi_slave_ar_addr(ar_addr), .axi_slave_ar_len(ar_len),
      .axi_slave_ar_size(ar_size), .axi_slave_ar_id(ar_id), .axi_slave_ar_prot(ar_prot),
      .axi_slave_ar_region(ar_region), .axi_slave_ar_burst(ar_burst), .axi_slave_ar_lock(ar_lock),
      .axi_slave_ar_cache(ar_cache), .axi_slave_ar_qos(ar_qos), .axi_slave_ar_user(ar_user),
      .axi_slave_ar_ready(ar_ready),
      .axi_slave_r_valid(r_valid), .axi_slave_r_data(r_data), .axi_slave_r_resp(r_resp),
      .axi_slave_r_last(r_last), .axi_slave_r_id(r_id), .axi_slave_r_user(r_user),
      .axi_slave_r_ready(r_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 64'(act), 64'(exp));
   endtask

   task automatic tfail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Reference model: flat byte array, 8-byte words, index wraps at 256 words.
   function automatic logic [1:0] ref_resp(input logic [31:0] addr, input logic [7:0] len);
`ifdef ADBG_AXI_MEM_SLAVE_RANGE_CHECK_EN
      if (addr >= 32'd2048) return 2'b11;
`endif
      if (len != 8'd0) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int ref_base(input logic [31:0] addr);
      return int'((addr / 8) % 256) * 8;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id,
                              input logic [63:0] data, input logic [7:0] strb);
      exp_t e;
      e.resp = ref_resp(addr, len);
      e.id   = id;
      e.data = '0;
      if (e.resp == 2'b00)
         for (int i = 0; i < 8; i++)
            if (strb[i]) ref_mem[ref_base(addr) + i] = data[8*i +: 8];
      exp_b.push_back(e);
   endtask

   task automatic model_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id);
      exp_t e;
      e.resp = ref_resp(addr, len);
      e.id   = id;
      e.data = '0;
      if (e.resp == 2'b00)
         for (int i = 0; i < 8; i++) e.data[8*i +: 8] = ref_mem[ref_base(addr) + i];
      exp_r.push_back(e);
   endtask

   // Response-channel backpressure driver.
   initial begin
      b_ready = 1'b0;
      r_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (bp_mode)
            0:       begin b_ready = ($urandom_range(0, 3) != 0); r_ready = ($urandom_range(0, 3) != 0); end
            1:       begin b_ready = 1'b0; r_ready = 1'b0; end
            default: begin b_ready = 1'b1; r_ready = 1'b1; end
         endcase
      end
   end

   // Monitor: a valid&ready seen at the falling edge completes on the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (axi_aresetn && b_valid && b_ready) begin
            if (exp_b.size() == 0) tfail("b_unexpected");
            else begin
               e = exp_b.pop_front();
               chk("b_resp", 64'(b_resp), 64'(e.resp));
               chk("b_id", 64'(b_id), 64'(e.id));
               chk("b_user", 64'(b_user), 64'd0);
            end
         end
         if (axi_aresetn && r_valid && r_ready) begin
            if (exp_r.size() == 0) tfail("r_unexpected");
            else begin
               e = exp_r.pop_front();
               chk("r_data", r_data, e.data);
               chk("r_resp", 64'(r_resp), 64'(e.resp));
               chk("r_id", 64'(r_id), 64'(e.id));
               chk1("r_last", r_last, 1'b1);
               chk("r_user", 64'(r_user), 64'd0);
            end
         end
      end
   end

   task automatic set_bp(input int m);
      bp_mode = m;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   // sel: 0 aw&w, 1 aw, 2 w, 3 ar. Returns #1 after the handshake edge.
   task automatic wait_rdy(input int sel, output logic rv);
      int  n = 0;
      logic done = 1'b0;
      logic ok;
      rv = 1'b0;
      while (!done) begin
         @(negedge clk);
         case (sel)
            0:       ok = aw_ready && w_ready;
            1:       ok = aw_ready;
            2:       ok = w_ready;
            default: ok = ar_ready;
         endcase
         if (ok) begin rv = r_valid; done = 1'b1; end
         else begin
            n++;
            if (n > 200) begin tfail("ready_wait"); done = 1'b1; end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_b();
      int n = 0;
      while (exp_b.size() != 0 && n <= 300) begin @(negedge clk); n++; end
      if (exp_b.size() != 0) begin tfail("b_wait"); exp_b.delete(); end
      @(posedge clk); #1;
   endtask

   task automatic wait_r();
      int n = 0;
      while (exp_r.size() != 0 && n <= 300) begin @(negedge clk); n++; end
      if (exp_r.size() != 0) begin tfail("r_wait"); exp_r.delete(); end
      @(posedge clk); #1;
   endtask

   // mode 0: aw+w together; 1: aw then w after gap; 2: w then aw after gap.
   task automatic write_issue(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id,
                              input logic [63:0] data, input logic [7:0] strb, input int mode, input int gap);
      logic rv;
      model_write(addr, len, id, data, strb);
      aw_addr = addr; aw_len = len; aw_id = id; aw_size = 3'd3;
      w_data = data; w_strb = strb; w_last = 1'b1;
      if (mode == 0) begin
         aw_valid = 1'b1; w_valid = 1'b1;
         wait_rdy(0, rv);
         aw_valid = 1'b0; w_valid = 1'b0;
      end else if (mode == 1) begin
         aw_valid = 1'b1;
         wait_rdy(1, rv);
         aw_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk1("wait_w_w_ready", w_ready, 1'b1);
            chk1("wait_w_aw_ready", aw_ready, 1'b0);
            @(posedge clk); #1;
         end
         w_valid = 1'b1;
         wait_rdy(2, rv);
         w_valid = 1'b0;
      end else begin
         w_valid = 1'b1;
         wait_rdy(2, rv);
         w_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk1("wait_aw_aw_ready", aw_ready, 1'b1);
            chk1("wait_aw_w_ready", w_ready, 1'b0);
            chk1("wait_aw_ar_ready", ar_ready, 1'b0);
            @(posedge clk); #1;
         end
         aw_valid = 1'b1;
         wait_rdy(1, rv);
         aw_valid = 1'b0;
      end
      chk1("b_valid_latency", b_valid, 1'b1);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id,
                           input logic [63:0] data, input logic [7:0] strb, input int mode, input int gap);
      write_issue(addr, len, id, data, strb, mode, gap);
      wait_b();
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id, input bit push);
      logic rv;
      if (push) model_read(addr, len, id);
      ar_addr = addr; ar_len = len; ar_id = id; ar_size = 3'd3;
      ar_valid = 1'b1;
      wait_rdy(3, rv);
      ar_valid = 1'b0;
      chk1("r_valid_before_hs", rv, 1'b0);
      chk1("r_valid_latency", r_valid, 1'b1);
      if (push) wait_r();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        rv;
      logic [31:0] a;
      logic [63:0] d;
      axi_aresetn = 1'b0;
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      aw_addr = '0; aw_len = '0; aw_size = 3'd3; aw_id = '0; w_data = '0; w_strb = '0; w_last = 1'b1;
      ar_addr = '0; ar_len = '0; ar_size = 3'd3; ar_id = '0;
      aw_prot = 3'd5; aw_region = 4'hA; aw_burst = 2'd1; aw_lock = 1'b1; aw_cache = 4'h3; aw_qos = 4'h7;
      aw_user = 6'h2A; w_user = 6'h15;
      ar_prot = 3'd2; ar_region = 4'h5; ar_burst = 2'd2; ar_lock = 1'b1; ar_cache = 4'hC; ar_qos = 4'h9;
      ar_user = 6'h33;

      repeat (3) @(posedge clk); #1;
      chk1("rst_aw_ready", aw_ready, 1'b0);
      chk1("rst_w_ready", w_ready, 1'b0);
      chk1("rst_ar_ready", ar_ready, 1'b0);
      chk1("rst_b_valid", b_valid, 1'b0);
      chk1("rst_r_valid", r_valid, 1'b0);
      chk("rst_b_resp", 64'(b_resp), 64'd0);
      chk("rst_r_resp", 64'(r_resp), 64'd0);
      chk("rst_r_data", r_data, 64'd0);
      @(negedge clk); #2;
      axi_aresetn = 1'b1;
      set_bp(2);
      @(negedge clk);
      chk1("idle_aw_ready", aw_ready, 1'b1);
      chk1("idle_w_ready", w_ready, 1'b1);
      chk1("idle_ar_ready", ar_ready, 1'b1);
      @(posedge clk); #1;

      for (int w = 0; w < 32; w++)
         do_write(32'(w * 8), 8'd0, 3'(w), {$urandom, $urandom}, 8'hFF, w % 3, w % 3);

      // Simultaneous aw+w then read back.
      do_write(32'h10, 8'd0, 3'd1, 64'h1122334455667788, 8'hFF, 0, 0);
      do_read(32'h10, 8'd0, 3'd2, 1'b1);

      // w three cycles ahead of aw, partial strobe over zero.
      do_write(32'h18, 8'd0, 3'd3, 64'd0, 8'hFF, 0, 0);
      do_write(32'h18, 8'd0, 3'd4, 64'hAAAAAAAABBBBBBBB, 8'h0F, 2, 3);
      do_read(32'h18, 8'd0, 3'd5, 1'b1);

      // Write and read arrive together: write wins, read waits for the b handshake.
      d = {$urandom, $urandom};
      model_write(32'h28, 8'd0, 3'd2, d, 8'hFF);
      model_read(32'h28, 8'd0, 3'd3);
      aw_addr = 32'h28; aw_len = 8'd0; aw_id = 3'd2; w_data = d; w_strb = 8'hFF;
      ar_addr = 32'h28; ar_len = 8'd0; ar_id = 3'd3;
      aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
      @(negedge clk);
      chk1("prio_ar_ready_idle", ar_ready, 1'b0);
      chk1("prio_aw_ready_idle", aw_ready, 1'b1);
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      chk1("prio_ar_ready_wr_resp", ar_ready, 1'b0);
      chk1("prio_b_valid", b_valid, 1'b1);
      wait_rdy(3, rv);
      ar_valid = 1'b0;
      chk1("prio_r_valid", r_valid, 1'b1);
      wait_r();

      // b_ready held low: response must stay put and no aw accepted.
      set_bp(1);
      write_issue(32'h20, 8'd0, 3'd5, {$urandom, $urandom}, 8'hFF, 0, 0);
      aw_addr = 32'h30; aw_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk1("stall_b_valid", b_valid, 1'b1);
         chk("stall_b_id", 64'(b_id), 64'd5);
         chk("stall_b_resp", 64'(b_resp), 64'd0);
         chk1("stall_aw_ready", aw_ready, 1'b0);
      end
      aw_valid = 1'b0;
      set_bp(2);
      wait_b();

      // Burst length errors and the out-of-range address.
      do_write(32'h30, 8'd3, 3'd6, {$urandom, $urandom}, 8'hFF, 0, 0);
      do_read(32'h30, 8'd0, 3'd7, 1'b1);
      do_read(32'h30, 8'd2, 3'd1, 1'b1);
      do_read(32'h800, 8'd0, 3'd2, 1'b1);

      set_bp(0);
      for (int n = 0; n < 200; n++) begin
         a = 32'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
         if ($urandom_range(0, 4) == 0) a = a | (32'($urandom_range(1, 15)) << 11);
         if ($urandom_range(0, 1) == 0)
            do_write(a, ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                     3'($urandom), {$urandom, $urandom}, 8'($urandom),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         else
            do_read(a, ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                    3'($urandom), 1'b1);
      end

      // Reset while a read response is pending: it is dropped, memory survives.
      set_bp(1);
      do_read(32'h40, 8'd0, 3'd6, 1'b0);
      #2;
      axi_aresetn = 1'b0;
      #1;
      chk1("rst_mid_r_valid", r_valid, 1'b0);
      chk("rst_mid_r_data", r_data, 64'd0);
      chk1("rst_mid_ar_ready", ar_ready, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); #2;
      axi_aresetn = 1'b1;
      set_bp(2);
      @(negedge clk);
      chk1("post_rst_r_valid", r_valid, 1'b0);
      chk1("post_rst_aw_ready", aw_ready, 1'b1);
      @(posedge clk); #1;
      do_read(32'h40, 8'd0, 3'd6, 1'b1);
      do_read(32'h10, 8'd0, 3'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
